// File: rtl/issue_unit.sv
`default_nettype none
// =============================================================================
//  Module   : issue_unit
//  Purpose  : Grants one issue-queue read per cycle (int/mul/div) while keeping
//             the single CDB conflict-free through a result reservation map.
//             Optional round-robin int/mul arbitration: define IU_RR_EN.
//  Revision : 1.0  initial release
// =============================================================================
module issue_unit #(
    parameter int INT_LAT = 1,
    parameter int MUL_LAT = 4,
    parameter int DIV_LAT = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       iq_int_rdy,
    input  logic       iq_mul_rdy,
    input  logic       iq_div_rdy,
    input  logic       cdb_flush,
    output logic       iu_int_r_en,
    output logic       iu_mul_r_en,
    output logic       iu_div_r_en,
    output logic       iu_div_busy,
    output logic [1:0] iu_cdb_src
);

    localparam int               CNT_W        = $clog2(DIV_LAT);
    localparam logic [1:0]       c_SRC_NONE   = 2'd0;
    localparam logic [1:0]       c_SRC_INT    = 2'd1;
    localparam logic [1:0]       c_SRC_MUL    = 2'd2;
    localparam logic [1:0]       c_SRC_DIV    = 2'd3;
    localparam logic [CNT_W-1:0] c_DIV_RELOAD = CNT_W'(DIV_LAT - 1);

    // r_res[k] names the unit that owns the CDB k cycles from now
    logic [1:0]       r_res [DIV_LAT];
    logic [CNT_W-1:0] r_div_cnt;

    logic w_int_elig;
    logic w_mul_elig;
    logic w_div_elig;
    logic w_gnt_int;
    logic w_gnt_mul;
    logic w_gnt_div;

    assign iu_div_busy = (r_div_cnt != '0);
    assign iu_cdb_src  = r_res[0];

    // The divider result slot lies one past the map, so only occupancy gates it
    assign w_int_elig = iq_int_rdy && (r_res[INT_LAT] == c_SRC_NONE) && !cdb_flush;
    assign w_mul_elig = iq_mul_rdy && (r_res[MUL_LAT] == c_SRC_NONE) && !cdb_flush;
    assign w_div_elig = iq_div_rdy && !iu_div_busy && !cdb_flush;

`ifdef IU_RR_EN
    // r_pref_mul set: mul wins the next int/mul tie
    logic r_pref_mul;

    always_comb begin
        w_gnt_div = w_div_elig;
        w_gnt_mul = 1'b0;
        w_gnt_int = 1'b0;
        if (!w_div_elig) begin
            if (w_int_elig && w_mul_elig) begin
                w_gnt_mul = r_pref_mul;
                w_gnt_int = !r_pref_mul;
            end else begin
                w_gnt_mul = w_mul_elig;
                w_gnt_int = w_int_elig;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_pref_mul <= 1'b0;
        end else if (w_gnt_int) begin
            r_pref_mul <= 1'b1;
        end else if (w_gnt_mul) begin
            r_pref_mul <= 1'b0;
        end
    end
`else
    always_comb begin
        w_gnt_div = w_div_elig;
        w_gnt_mul = w_mul_elig && !w_div_elig;
        w_gnt_int = w_int_elig && !w_div_elig && !w_mul_elig;
    end
`endif

    assign iu_int_r_en = w_gnt_int;
    assign iu_mul_r_en = w_gnt_mul;
    assign iu_div_r_en = w_gnt_div;

    // Shift the map one slot per cycle; a grant claims its result slot
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int k = 0; k < DIV_LAT; k++) begin
                r_res[k] <= c_SRC_NONE;
            end
        end else begin
            for (int k = 0; k < DIV_LAT - 1; k++) begin
                r_res[k] <= r_res[k+1];
            end
            r_res[DIV_LAT-1] <= c_SRC_NONE;
            if (w_gnt_int) begin
                r_res[INT_LAT-1] <= c_SRC_INT;
            end
            if (w_gnt_mul) begin
                r_res[MUL_LAT-1] <= c_SRC_MUL;
            end
            if (w_gnt_div) begin
                r_res[DIV_LAT-1] <= c_SRC_DIV;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_div_cnt <= '0;
        end else if (w_gnt_div) begin
            r_div_cnt <= c_DIV_RELOAD;
        end else if (iu_div_busy) begin
            r_div_cnt <= r_div_cnt - 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_issue_unit.sv
`default_nettype none
// =============================================================================
//  Module   : tb_issue_unit
//  Purpose  : Directed and randomized checks of issue_unit against an
//             absolute-cycle CDB schedule model. Define IU_RR_EN to match RTL.
//  Revision : 1.0  initial release
// =============================================================================
module tb_issue_unit;

    localparam int INT_LAT = 1;
    localparam int MUL_LAT = 4;
    localparam int DIV_LAT = 8;

    logic       clk;
    logic       reset;
    logic       iq_int_rdy;
    logic       iq_mul_rdy;
    logic       iq_div_rdy;
    logic       cdb_flush;
    logic       iu_int_r_en;
    logic       iu_mul_r_en;
    logic       iu_div_r_en;
    logic       iu_div_busy;
    logic [1:0] iu_cdb_src;

    issue_unit #(
        .INT_LAT (INT_LAT),
        .MUL_LAT (MUL_LAT),
        .DIV_LAT (DIV_LAT)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .iq_int_rdy  (iq_int_rdy),
        .iq_mul_rdy  (iq_mul_rdy),
        .iq_div_rdy  (iq_div_rdy),
        .cdb_flush   (cdb_flush),
        .iu_int_r_en (iu_int_r_en),
        .iu_mul_r_en (iu_mul_r_en),
        .iu_div_r_en (iu_div_r_en),
        .iu_div_busy (iu_div_busy),
        .iu_cdb_src  (iu_cdb_src)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: CDB owner per absolute cycle, divider free-from cycle
    int       t = 0;
    bit [1:0] owner [int];
    int       div_free = 0;
    bit       pref_mul = 1'b0;

    bit       m_gi, m_gm, m_gd, m_busy;
    bit [1:0] m_cdb;
    logic       o_gi, o_gm, o_gd, o_busy;
    logic [1:0] o_cdb;

    function automatic bit slot_free(input int c);
        return !owner.exists(c) || owner[c] == 2'd0;
    endfunction

    // Apply inputs for one cycle, capture DUT and model values mid-cycle
    task automatic run_cycle(input bit ir, input bit mr, input bit dr,
                             input bit fl, input bit rs);
        bit e_int, e_mul, e_div;
        iq_int_rdy = ir;
        iq_mul_rdy = mr;
        iq_div_rdy = dr;
        cdb_flush  = fl;
        reset      = rs;
        @(negedge clk);
        m_cdb  = owner.exists(t) ? owner[t] : 2'd0;
        m_busy = (t < div_free);
        e_int  = ir && !fl && slot_free(t + INT_LAT);
        e_mul  = mr && !fl && slot_free(t + MUL_LAT);
        e_div  = dr && !fl && !m_busy;
        m_gd = e_div;
        m_gm = 1'b0;
        m_gi = 1'b0;
        if (!e_div) begin
`ifdef IU_RR_EN
            if (e_int && e_mul) begin
                m_gm = pref_mul;
                m_gi = !pref_mul;
            end else begin
                m_gm = e_mul;
                m_gi = e_int;
            end
`else
            m_gm = e_mul;
            m_gi = e_int && !e_mul;
`endif
        end
        o_gi   = iu_int_r_en;
        o_gm   = iu_mul_r_en;
        o_gd   = iu_div_r_en;
        o_busy = iu_div_busy;
        o_cdb  = iu_cdb_src;
        if (rs) begin
            owner.delete();
            div_free = 0;
            pref_mul = 1'b0;
        end else begin
            if (m_gi) begin owner[t + INT_LAT] = 2'd1; pref_mul = 1'b1; end
            if (m_gm) begin owner[t + MUL_LAT] = 2'd2; pref_mul = 1'b0; end
            if (m_gd) begin owner[t + DIV_LAT] = 2'd3; div_free = t + DIV_LAT; end
        end
        @(posedge clk);
        #1;
        t++;
    endtask

    task automatic test_reset();
        run_cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        run_cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        run_cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        n_tests++;
        if (o_cdb !== 2'd0) begin
            n_fail++; $display("FAIL reset_cdb_src: got %0d expected 0", o_cdb);
        end
        n_tests++;
        if (o_busy !== 1'b0) begin
            n_fail++; $display("FAIL reset_div_busy: got %b expected 0", o_busy);
        end
        n_tests++;
        if ({o_gi, o_gm, o_gd} !== 3'b000) begin
            n_fail++; $display("FAIL reset_grants: got %b expected 000", {o_gi, o_gm, o_gd});
        end
    endtask

    task automatic test_int_stream();
        run_cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        for (int k = 0; k < 5; k++) begin
            run_cycle(k < 3, 1'b0, 1'b0, 1'b0, 1'b0);
            n_tests++;
            if (o_gi !== (k < 3)) begin
                n_fail++; $display("FAIL int_stream_grant c%0d: got %b expected %b", k, o_gi, k < 3);
            end
            n_tests++;
            if (o_cdb !== ((k >= 1 && k <= 3) ? 2'd1 : 2'd0)) begin
                n_fail++; $display("FAIL int_stream_cdb c%0d: got %0d", k, o_cdb);
            end
        end
    endtask

    task automatic test_mul_block();
        bit [1:0] exp_cdb [7] = '{2'd0, 2'd0, 2'd1, 2'd1, 2'd2, 2'd1, 2'd0};
        bit       exp_gi  [7] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
        run_cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        for (int k = 0; k < 7; k++) begin
            run_cycle(k >= 1 && k <= 4, k == 0, 1'b0, 1'b0, 1'b0);
            n_tests++;
            if (o_gm !== (k == 0)) begin
                n_fail++; $display("FAIL mul_block_mgrant c%0d: got %b", k, o_gm);
            end
            n_tests++;
            if (o_gi !== exp_gi[k]) begin
                n_fail++; $display("FAIL mul_block_igrant c%0d: got %b expected %b", k, o_gi, exp_gi[k]);
            end
            n_tests++;
            if (o_cdb !== exp_cdb[k]) begin
                n_fail++; $display("FAIL mul_block_cdb c%0d: got %0d expected %0d", k, o_cdb, exp_cdb[k]);
            end
        end
    endtask

    task automatic test_div();
        run_cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        for (int k = 0; k <= DIV_LAT; k++) begin
            run_cycle(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
            n_tests++;
            if (o_gd !== (k == 0 || k == DIV_LAT)) begin
                n_fail++; $display("FAIL div_grant c%0d: got %b", k, o_gd);
            end
            n_tests++;
            if (o_busy !== (k >= 1 && k < DIV_LAT)) begin
                n_fail++; $display("FAIL div_busy c%0d: got %b", k, o_busy);
            end
            n_tests++;
            if (o_cdb !== ((k == DIV_LAT) ? 2'd3 : 2'd0)) begin
                n_fail++; $display("FAIL div_cdb c%0d: got %0d", k, o_cdb);
            end
        end
    endtask

    task automatic test_flush_reset();
        for (int pass = 0; pass < 2; pass++) begin
            run_cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
            run_cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
            run_cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
            run_cycle(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
            n_tests++;
            if ({o_gi, o_gm, o_gd} !== 3'b000) begin
                n_fail++; $display("FAIL flush_grants p%0d: got %b expected 000", pass, {o_gi, o_gm, o_gd});
            end
            run_cycle(1'b0, 1'b0, 1'b0, 1'b0, pass == 1);
            run_cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
            n_tests++;
            if (o_cdb !== ((pass == 0) ? 2'd2 : 2'd0)) begin
                n_fail++; $display("FAIL flush_cdb p%0d: got %0d expected %0d", pass, o_cdb, (pass == 0) ? 2 : 0);
            end
        end
    endtask

    task automatic test_arbitration();
        run_cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        for (int k = 0; k < 8; k++) begin
            run_cycle(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
`ifdef IU_RR_EN
            if (k < 4) begin
                n_tests++;
                if ({o_gi, o_gm} !== ((k % 2 == 0) ? 2'b10 : 2'b01)) begin
                    n_fail++; $display("FAIL rr_alternate c%0d: got int=%b mul=%b", k, o_gi, o_gm);
                end
            end else begin
                n_tests++;
                if ({o_gi, o_gm} !== {m_gi, m_gm}) begin
                    n_fail++; $display("FAIL rr_model c%0d: got %b%b expected %b%b", k, o_gi, o_gm, m_gi, m_gm);
                end
            end
`else
            n_tests++;
            if ({o_gi, o_gm} !== 2'b01) begin
                n_fail++; $display("FAIL fixed_prio c%0d: got int=%b mul=%b expected mul", k, o_gi, o_gm);
            end
`endif
        end
    endtask

    task automatic test_random();
        run_cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        for (int k = 0; k < 400; k++) begin
            run_cycle($urandom_range(0, 99) < 60, $urandom_range(0, 99) < 50,
                      $urandom_range(0, 99) < 30, $urandom_range(0, 99) < 8,
                      $urandom_range(0, 99) < 2);
            n_tests++;
            if ({o_gi, o_gm, o_gd} !== {m_gi, m_gm, m_gd}) begin
                n_fail++; $display("FAIL rand_grants c%0d: got %b expected %b", k, {o_gi, o_gm, o_gd}, {m_gi, m_gm, m_gd});
            end
            n_tests++;
            if (o_busy !== m_busy) begin
                n_fail++; $display("FAIL rand_busy c%0d: got %b expected %b", k, o_busy, m_busy);
            end
            n_tests++;
            if (o_cdb !== m_cdb) begin
                n_fail++; $display("FAIL rand_cdb c%0d: got %0d expected %0d", k, o_cdb, m_cdb);
            end
        end
    endtask

    initial begin
        reset      = 1'b1;
        iq_int_rdy = 1'b0;
        iq_mul_rdy = 1'b0;
        iq_div_rdy = 1'b0;
        cdb_flush  = 1'b0;
        @(posedge clk);
        #1;
        test_reset();
        test_int_stream();
        test_mul_block();
        test_div();
        test_flush_reset();
        test_arbitration();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
